// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, parameter floors and constant-width helpers
// for the button conditioner bank (debounce_channel / debounce_sync_bank).
package debounce_pkg;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  // Smallest legal values; out-of-range parameters are clamped up to these.
  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MIN_STABLE_CYCLES = 2;
  localparam int MIN_REPEAT_CYCLES = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button input.
//   raw in -> SYNC_STAGES flop synchroniser -> stability counter -> out,
//   one-cycle rise/fall pulses, optional hold-to-repeat pulse stream.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in         raw asynchronous button level
//   out        debounced level
//   rise/fall  one-cycle pulses on out 0->1 / 1->0
//   rep        auto-repeat pulse while out is held (0 when REPEAT_EN=0)
//   out_next   combinational next value of out (feeds the bank's any_active)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic rep,
  output logic out_next
);

  localparam int SN = imax(SYNC_STAGES, MIN_SYNC_STAGES);
  localparam int SC = imax(STABLE_CYCLES, MIN_STABLE_CYCLES);
  localparam int CW = clog2(SC);
  localparam logic [CW-1:0] CNT_MAX = CW'(SC - 1);

  logic [SN-1:0] sync_q;
  logic          sync;
  logic [CW-1:0] cnt;

  assign sync = sync_q[SN-1];

  // out only flips once the disagreement has lasted SC consecutive edges.
  always_comb begin
    out_next = out;
    if (sync != out && cnt == CNT_MAX) out_next = sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      out    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SN-2:0], in};
      out    <= out_next;
      rise   <= out_next & ~out;
      fall   <= ~out_next & out;
      // Any edge where sync agrees with out (glitch back) restarts the count.
      if (sync == out || cnt == CNT_MAX) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
    end
  end

  if (REPEAT_EN != 0) begin : g_rep
    localparam int RD = imax(REPEAT_DELAY, MIN_REPEAT_CYCLES);
    localparam int RP = imax(REPEAT_PERIOD, MIN_REPEAT_CYCLES);
    localparam int RW = clog2(imax(RD, RP) + 1);
    localparam logic [RW-1:0] DLY_MAX = RW'(RD - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(RP - 1);

    rep_state_t    st;
    logic [RW-1:0] rcnt;
    logic          rep_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        st    <= REP_IDLE;
        rcnt  <= '0;
        rep_q <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        case (st)
          REP_IDLE: begin
            rcnt <= '0;
            if (out_next & ~out) st <= REP_DELAY;
          end
          REP_DELAY, REP_REPEAT: begin
            // Release wins over a pulse due on the same edge.
            if (!out_next) begin
              st   <= REP_IDLE;
              rcnt <= '0;
            end else if (rcnt == ((st == REP_DELAY) ? DLY_MAX : PER_MAX)) begin
              st    <= REP_REPEAT;
              rcnt  <= '0;
              rep_q <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            st   <= REP_IDLE;
            rcnt <= '0;
          end
        endcase
      end
    end

    assign rep = rep_q;
  end else begin : g_norep
    assign rep = 1'b0;
  end

endmodule

// File: rtl/debounce_sync_bank.sv
// debounce_sync_bank: CHANNELS independent button conditioners plus a
// registered "any button down" flag.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in          raw asynchronous button inputs
//   out         debounced levels
//   rise/fall   one-cycle edge pulses per channel
//   rep         one-cycle auto-repeat pulses per channel
//   any_active  registered OR of out (changes on the same edge as out)
module debounce_sync_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rep,
  output logic                any_active
);

  logic [CHANNELS-1:0] out_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in      (in[i]),
      .out     (out[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .rep     (rep[i]),
      .out_next(out_next[i])
    );
  end

  // Built from next-state out so it lands on the same edge as out.
  always_ff @(posedge clk) begin
    if (rst) any_active <= 1'b0;
    else     any_active <= |out_next;
  end

endmodule

// File: tb/tb_debounce_sync_bank.sv
module tb_debounce_sync_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic [1:0] out, rise, fall, rep;
  logic       any_active;
  logic [1:0] out2, rise2, fall2, rep2;
  logic       any2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounce_sync_bank #(
    .CHANNELS(2), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .rise(rise), .fall(fall),
    .rep(rep), .any_active(any_active)
  );

  // Same stimulus with repeat logic removed.
  debounce_sync_bank #(
    .CHANNELS(2), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_norep (
    .clk(clk), .rst(rst), .in(in), .out(out2), .rise(rise2), .fall(fall2),
    .rep(rep2), .any_active(any2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 2'b00;
    tick(2);
    chk("reset_out",  32'(out), 0);
    chk("reset_rise", 32'(rise), 0);
    chk("reset_fall", 32'(fall), 0);
    chk("reset_rep",  32'(rep), 0);
    chk("reset_any",  32'(any_active), 0);
    rst = 1'b0;
    tick(3);

    // Clean press: first sampled at edge k, out/rise at k+5.
    in = 2'b01;
    tick(5);
    chk("press_early_out", 32'(out), 0);
    chk("press_early_any", 32'(any_active), 0);
    tick(1);
    chk("press_out",  32'(out), 32'b01);
    chk("press_rise", 32'(rise), 32'b01);
    chk("press_any",  32'(any_active), 1);
    chk("press_fall", 32'(fall), 0);
    // Rise edge = R; rep at R+10, R+15, R+20.
    tick(1);
    chk("press_rise_onecyc", 32'(rise), 0);
    chk("press_out_hold",    32'(out), 32'b01);
    tick(8);
    chk("rep_before_delay", 32'(rep), 0);
    tick(1);
    chk("rep_first",   32'(rep), 32'b01);
    chk("norep_first", 32'(rep2), 0);
    tick(1);
    chk("rep_first_onecyc", 32'(rep), 0);
    tick(3);
    chk("rep_before_period", 32'(rep), 0);
    tick(1);
    chk("rep_second", 32'(rep), 32'b01);
    tick(5);
    chk("rep_third", 32'(rep), 32'b01);

    // Release sampled at R+21 -> fall at R+26; a rep still lands at R+25.
    in = 2'b00;
    tick(5);
    chk("rel_early_out", 32'(out), 32'b01);
    chk("rel_rep_r25",   32'(rep), 32'b01);
    tick(1);
    chk("rel_out",  32'(out), 0);
    chk("rel_fall", 32'(fall), 32'b01);
    chk("rel_rise", 32'(rise), 0);
    chk("rel_rep",  32'(rep), 0);
    chk("rel_any",  32'(any_active), 0);
    tick(4);
    chk("rel_no_rep_after", 32'(rep), 0);
    chk("rel_fall_onecyc",  32'(fall), 0);

    // Bounce: high 2, low 1, repeated; never reaches 4 stable edges.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        in = (c < 2) ? 2'b01 : 2'b00;
        tick(1);
        chk("bounce_out",  32'(out), 0);
        chk("bounce_rise", 32'(rise), 0);
      end
    end
    in = 2'b01;
    tick(5);
    chk("steady_early_out", 32'(out), 0);
    tick(1);
    chk("steady_rise", 32'(rise), 32'b01);
    chk("steady_out",  32'(out), 32'b01);
    tick(1);
    chk("steady_rise_once", 32'(rise), 0);
    in = 2'b00;
    tick(6);
    chk("steady_rel_out",  32'(out), 0);
    chk("steady_rel_fall", 32'(fall), 32'b01);

    // Both channels together.
    in = 2'b11;
    tick(5);
    chk("sim_early_out", 32'(out), 0);
    tick(1);
    chk("sim_out",  32'(out), 32'b11);
    chk("sim_rise", 32'(rise), 32'b11);
    chk("sim_any",  32'(any_active), 1);
    tick(9);
    chk("sim_rep_before", 32'(rep), 0);
    tick(1);
    chk("sim_rep",   32'(rep), 32'b11);
    chk("sim_norep", 32'(rep2), 0);
    tick(5);
    chk("sim_rep2", 32'(rep), 32'b11);
    in = 2'b00;
    tick(6);
    chk("sim_fall", 32'(fall), 32'b11);
    chk("sim_rel_out", 32'(out), 0);

    // Reset in the middle of DELAY with the button held.
    in = 2'b01;
    tick(6);
    chk("mr_rise", 32'(rise), 32'b01);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mr_out",  32'(out), 0);
    chk("mr_rise0", 32'(rise), 0);
    chk("mr_fall", 32'(fall), 0);
    chk("mr_rep",  32'(rep), 0);
    chk("mr_any",  32'(any_active), 0);
    rst = 1'b0;
    tick(5);
    chk("mr_refill_out", 32'(out), 0);
    tick(1);
    chk("mr_rerise_out",  32'(out), 32'b01);
    chk("mr_rerise_rise", 32'(rise), 32'b01);
    chk("mr_rerise_any",  32'(any_active), 1);
    tick(9);
    chk("mr_rep_before", 32'(rep), 0);
    tick(1);
    chk("mr_rep_fresh", 32'(rep), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_sync_bank.md
Name: debounce_sync_bank

Overview:
- Multi-channel, parametrised button conditioner for the PacMan board inputs (direction pad, start, pause).
- Each channel runs raw asynchronous input → N-flop synchroniser → counter-based stability filter → clean level plus one-cycle rise/fall pulses.
- Optional hold-to-repeat pulse stream per channel, for continuous movement while a direction button is held.
- Sits between the top-level button pins and the game FSM / movement logic.

Parameters:
- CHANNELS, 5, number of independent inputs.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range ≥2.
- STABLE_CYCLES, 16, consecutive clocks the synchronised level must differ from out before out flips; legal range ≥2.
- REPEAT_EN, 1, 1 = repeat logic active; 0 = rep tied 0 and repeat logic removed.
- REPEAT_DELAY, 1000, clocks from rise pulse to first rep pulse; must be ≥1.
- REPEAT_PERIOD, 250, clocks between subsequent rep pulses; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in  in  CHANNELS  raw button inputs, asynchronous
- out  out  CHANNELS  debounced level
- rise  out  CHANNELS  one-cycle pulse when out goes 0→1
- fall  out  CHANNELS  one-cycle pulse when out goes 1→0
- rep  out  CHANNELS  one-cycle auto-repeat pulse while held
- any_active  out  1  OR-reduction of out, registered

Behaviour:
- Reset (rst=1 at a clk edge): clear all synchroniser flops, counters and repeat state; out, rise, fall, rep and any_active = 0 from the next cycle. Reset overrides any in-flight debounce or repeat.
- Synchroniser: in[i] shifts through SYNC_STAGES flops. sync[i] is the last stage.
- Stability filter, evaluated per channel per edge:
  - sync == out: cnt <= 0.
  - sync != out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - sync != out and cnt == STABLE_CYCLES-1: out <= sync, cnt <= 0.
- cnt width is $clog2(STABLE_CYCLES). cnt never wraps.
- Any glitch that returns sync to out restarts the count from 0.
- Latency: let k be the first edge that samples a new stable level on in. out changes on edge k+SYNC_STAGES+STABLE_CYCLES-1. rise or fall is asserted on that same edge for exactly one cycle.
- rise and fall are never both high on one channel. Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Repeat FSM per channel, when REPEAT_EN=1. States:
  - IDLE: on the edge that sets out → DELAY, rcnt <= 0.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY-1: rep pulse, rcnt <= 0, → REPEAT.
  - REPEAT: rcnt increments each cycle. When rcnt == REPEAT_PERIOD-1: rep pulse, rcnt <= 0, stay in REPEAT.
  - DELAY or REPEAT: on the edge that clears out → IDLE, rcnt <= 0, no rep in that cycle.
- rcnt width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- rep is never coincident with rise. The first rep follows rise by exactly REPEAT_DELAY cycles. Later rep pulses are spaced exactly REPEAT_PERIOD cycles apart.
- any_active is registered OR of the next-state out value, so it changes on the same edge as out.

Decomposition:
- Package debounce_pkg holds:
  - rep_state_t enum {REP_IDLE, REP_DELAY, REP_REPEAT}.
  - clog2-style helper function.
  - Parameter sanity limits.
- Sub-module debounce_channel contains the synchroniser, stability filter, edge pulses and repeat FSM for one bit.
- The top level generate-loops debounce_channel CHANNELS times and builds any_active.

Test Plan (CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: in[0] 0→1 sampled first at edge 10, held high → out[0]=1 and rise[0]=1 at edge 15 only; any_active=1 at edge 15; channel 1 stays 0.
- Bounce rejection: in[0] toggles high 2 cycles, low 1, high 2, low, repeating → out[0], rise[0] never assert. A subsequent 6-cycle steady high → single rise.
- Release: with out[0]=1, in[0]→0 sampled at edge k → out[0]=0 and fall[0]=1 at edge k+5, rep stops.
- Auto-repeat: hold in[0] high, rise at edge 15 → rep[0] at edges 25, 30, 35, …. Release → no rep after out falls. With REPEAT_EN=0, rep stays 0.
- Simultaneous channels: in=2'b11 at the same edge → rise=2'b11 in the same cycle, rep pulses aligned on both channels.
- Mid-operation reset: rst=1 for 1 cycle during DELAY with in held high → all outputs 0 next cycle. Then out re-rises 5 edges after rst deasserts (sync refilled), and a fresh rise pulse is issued.
